// File: rtl/pipelined_shifter.sv
// Pipelined shifter: SLL / SRL / SRA / ROTR on WIDTH-bit operands, with a
// 32-bit word mode whose result is sign-extended to WIDTH.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kills every in-flight operation; blocks accept
//   in_valid/in_ready     request handshake (in_data, in_amount, in_op,
//                         in_word, in_tag)
//   out_valid/out_ready   result handshake (out_data, out_tag)
//
// All ops are funnelled through one right-shifting datapath. SLL is done as
// reverse -> logical right shift -> reverse. Word ops are pre-conditioned so
// that the low 32 bits of the full-width result are the 32-bit answer:
// zero-extend for SRL, sign-extend for SRA, replicate the low word across
// the datapath for ROTR. The final stage sign-extends word results.
module pipelined_shifter #(
    parameter int WIDTH            = 64,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amount,
    input  logic [1:0]               in_op,
    input  logic                     in_word,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int AW  = $clog2(WIDTH);
    localparam int LPS = LEVELS_PER_STAGE;
    localparam int N   = (AW + LPS - 1) / LPS;
    localparam int NQ  = (N > 1) ? N - 1 : 1;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    amt;
        logic [1:0]       op;
        logic             word;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
        return r;
    endfunction

    // One mux level: right shift by sh with the fill the op calls for.
    function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] d,
                                             input int sh,
                                             input logic [1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SRA:  r = WIDTH'($signed(d) >>> sh);
            OP_ROTR: r = (d >> sh) | (d << (WIDTH - sh));
            default: r = d >> sh;
        endcase
        return r;
    endfunction

    // ---------------- handshake / valid pipe ----------------
    logic [N-1:0] vld_pipe_q, vld_pipe_d;
    logic         advance, accept;

    assign out_valid = vld_pipe_q[N-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !flush;
    assign accept    = in_valid && in_ready;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (flush) begin
            vld_pipe_d = '0;
        end else if (advance) begin
            vld_pipe_d[0] = accept;
            for (int s = 1; s < N; s++) vld_pipe_d[s] = vld_pipe_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe_q <= '0;
        else        vld_pipe_q <= vld_pipe_d;
    end

    // ---------------- operand conditioning ----------------
    stage_t pre;

    always_comb begin
        pre.amt  = in_word ? AW'(in_amount[4:0]) : in_amount;
        pre.op   = in_op;
        pre.word = in_word;
        pre.tag  = in_tag;
        if (in_op == OP_SLL) begin
            // Only the low word of the result matters in word mode, so the
            // full-width reversal works for both.
            pre.data = bitrev(in_data);
        end else if (!in_word) begin
            pre.data = in_data;
        end else begin
            case (in_op)
                OP_SRA:  pre.data = WIDTH'($signed(in_data[31:0]));
                OP_ROTR: pre.data = {(WIDTH/32){in_data[31:0]}};
                default: pre.data = WIDTH'(in_data[31:0]);
            endcase
        end
    end

    // ---------------- shift stages ----------------
    stage_t stg_q [NQ];
    stage_t src   [N];
    stage_t nxt   [N];

    always_comb begin
        src[0] = pre;
        for (int s = 1; s < N; s++) src[s] = stg_q[s-1];
    end

    // Stage s applies levels s*LPS .. s*LPS+LPS-1 (shift by 2^k).
    always_comb begin
        for (int s = 0; s < N; s++) begin
            nxt[s] = src[s];
            for (int k = 0; k < AW; k++) begin
                if (k >= s*LPS && k < (s+1)*LPS && src[s].amt[k])
                    nxt[s].data = shr(nxt[s].data, 1 << k, src[s].op);
            end
        end
    end

    // Intermediate datapath registers carry no reset; validity lives in
    // vld_pipe_q.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int s = 0; s < N-1; s++) stg_q[s] <= nxt[s];
        end
    end

    // ---------------- result formatting + output register ----------------
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;

    always_comb begin
        res_d = (nxt[N-1].op == OP_SLL) ? bitrev(nxt[N-1].data) : nxt[N-1].data;
        if (nxt[N-1].word) res_d = WIDTH'($signed(res_d[31:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else if (advance) begin
            out_data_q <= res_d;
            out_tag_q  <= nxt[N-1].tag;
        end
    end

    assign out_data = out_data_q;
    assign out_tag  = out_tag_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter (WIDTH=64, LEVELS_PER_STAGE=2, TAG_W=5).
// A negedge monitor keeps a queue of expected results (each entry counts
// the advancing edges it has seen; it must reach the output after N of
// them) and checks handshake, data and tag every cycle.
module tb_pipelined_shifter;

    localparam int W  = 64;
    localparam int TW = 5;
    localparam int AW = 6;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amount = '0;
    logic [1:0]    in_op = '0;
    logic          in_word = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    int vecs = 0;
    int errs = 0;
    int got  = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
        int            adv;
    } ent_t;
    ent_t q[$];

    pipelined_shifter #(.WIDTH(W), .LEVELS_PER_STAGE(2), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amount(in_amount), .in_op(in_op), .in_word(in_word), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Bit-by-bit statement of each operation.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [AW-1:0] a,
                                           input logic [1:0] op, input logic w);
        int wd;
        int n;
        logic [W-1:0] r;
        wd = w ? 32 : W;
        n  = w ? int'(a[4:0]) : int'(a);
        r  = '0;
        for (int i = 0; i < wd; i++) begin
            case (op)
                2'b00:   r[i] = (i >= n) ? d[i-n] : 1'b0;
                2'b01:   r[i] = (i + n < wd) ? d[i+n] : 1'b0;
                2'b10:   r[i] = (i + n < wd) ? d[i+n] : d[wd-1];
                default: r[i] = d[(i+n) % wd];
            endcase
        end
        if (w) for (int i = 32; i < W; i++) r[i] = r[31];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", W'(out_valid), '0);
            chk("rst_out_data", out_data, '0);
            chk("rst_out_tag", W'(out_tag), '0);
        end else begin
            logic exp_v;
            logic adv;
            ent_t e;
            exp_v = (q.size() > 0) && (q[0].adv == N);
            chk("out_valid", W'(out_valid), W'(exp_v));
            if (exp_v) begin
                chk("out_data", out_data, q[0].d);
                chk("out_tag", W'(out_tag), W'(q[0].t));
            end
            adv = !exp_v || out_ready;
            chk("in_ready", W'(in_ready), W'(adv && !flush));
            if (flush) begin
                q.delete();
            end else begin
                if (exp_v && out_ready) begin
                    void'(q.pop_front());
                    got++;
                end
                if (in_valid && adv) begin
                    e.d = model(in_data, in_amount, in_op, in_word);
                    e.t = in_tag;
                    e.adv = 0;
                    q.push_back(e);
                end
                if (adv) foreach (q[i]) q[i].adv++;
            end
        end
    end

    // Single op on an idle pipeline: literal result, tag and latency.
    task automatic op1(input string nm, input logic [W-1:0] d, input logic [AW-1:0] a,
                       input logic [1:0] op, input logic w, input logic [TW-1:0] t,
                       input logic [W-1:0] exp);
        int cyc;
        in_valid = 1'b1; in_data = d; in_amount = a; in_op = op; in_word = w; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(nm, out_data, exp);
        chk({nm, "_tag"}, W'(out_tag), W'(t));
        chk({nm, "_lat"}, W'(cyc), W'(N));
        @(posedge clk); #1;
    endtask

    task automatic idle_window(input string nm, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk(nm, W'(seen), '0);
    endtask

    initial begin
        int got0;
        int k;
        int cyc;
        logic acc;

        // model pinned by hand-computed values
        chk("model_sll63", model(64'h1, 6'd63, 2'b00, 1'b0), 64'h8000_0000_0000_0000);
        chk("model_sra4", model(64'h8000_0000_0000_0010, 6'd4, 2'b10, 1'b0), 64'hF800_0000_0000_0001);
        chk("model_wsll", model(64'hDEAD_BEEF_4000_0001, 6'd1, 2'b00, 1'b1), 64'hFFFF_FFFF_8000_0002);
        chk("model_wrotr", model(64'h1, 6'd1, 2'b11, 1'b1), 64'hFFFF_FFFF_8000_0000);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("in_ready_after_reset", W'(in_ready), 64'h1);
        @(posedge clk); #1;

        // directed literal cases
        op1("sll63",    64'h1,                   6'd63, 2'b00, 1'b0, 5'd3,  64'h8000_0000_0000_0000);
        op1("sra4",     64'h8000_0000_0000_0010, 6'd4,  2'b10, 1'b0, 5'd7,  64'hF800_0000_0000_0001);
        op1("srl4",     64'h8000_0000_0000_0010, 6'd4,  2'b01, 1'b0, 5'd8,  64'h0800_0000_0000_0001);
        op1("rotr8",    64'hFF,                  6'd8,  2'b11, 1'b0, 5'd9,  64'hFF00_0000_0000_0000);
        op1("rotr0",    64'h1234_5678_9ABC_DEF0, 6'd0,  2'b11, 1'b0, 5'd10, 64'h1234_5678_9ABC_DEF0);
        op1("w_sll1",   64'hDEAD_BEEF_4000_0001, 6'd1,  2'b00, 1'b1, 5'd11, 64'hFFFF_FFFF_8000_0002);
        op1("w_srl31",  64'h0000_0000_8000_0000, 6'd31, 2'b01, 1'b1, 5'd12, 64'h1);
        op1("w_rotr1",  64'h1,                   6'd1,  2'b11, 1'b1, 5'd13, 64'hFFFF_FFFF_8000_0000);
        op1("w_amt_hi", 64'hFFFF_FFFF_0000_00F0, 6'd36, 2'b01, 1'b1, 5'd14, 64'hF);
        op1("w_sra0",   64'h0000_0000_8000_0001, 6'd0,  2'b10, 1'b1, 5'd15, 64'hFFFF_FFFF_8000_0001);

        // 8 back-to-back accepts with a 4-cycle out_ready drop
        got0 = got; k = 0; cyc = 0;
        while (k < 8 && cyc < 40) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom}; in_amount = AW'($urandom);
            in_op = 2'($urandom); in_word = 1'($urandom); in_tag = TW'(k);
            out_ready = !(cyc >= 4 && cyc < 8);
            #3 acc = in_ready;
            if (!out_ready && out_valid) chk("stall_in_ready", W'(in_ready), '0);
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("stream_count", W'(got - got0), 64'd8);

        // flush with three operations in flight (held at output by a stall)
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom}; in_amount = AW'($urandom);
            in_op = 2'($urandom); in_word = 1'b0; in_tag = TW'(20 + i);
            @(posedge clk); #1;
        end
        out_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle_window("flush_no_out", 10);

        // reset mid-stream
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom}; in_amount = AW'($urandom);
            in_op = 2'($urandom); in_word = 1'($urandom); in_tag = TW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst_immediate", W'(out_valid), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_window("rst_no_out", 8);
        op1("post_rst", 64'h00F0, 6'd4, 2'b01, 1'b0, 5'd30, 64'h000F);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0:       in_amount = 6'd0;
                1:       in_amount = 6'd63;
                2:       in_amount = 6'd31;
                3:       in_amount = 6'd32;
                default: in_amount = AW'($urandom);
            endcase
            in_op     = 2'($urandom);
            in_word   = 1'($urandom);
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("drain", W'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
